// File: rtl/uart_tx_os.sv
// uart_tx_os: UART transmitter with a one-entry holding buffer.
// Frame: start(0), DATA_WIDTH data bits LSB first, optional parity, stop(1).
// Every bit lasts `prescale` CLK cycles. A prescale of 0 is treated as 1.
// Parity mode and prescale are captured when a frame starts, so changing
// them mid-frame only affects later frames.
module uart_tx_os #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  ready,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_buf;
  logic                  r_buf_full;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [PRESCALE_W-1:0] r_cnt;
  logic [PRESCALE_W-1:0] r_last;
  logic [BIT_W-1:0]      r_bit;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  r_tx;
  logic                  r_busy;

  logic                  w_bit_done;
  logic                  w_load;
  logic                  w_accept;
  logic [PRESCALE_W-1:0] w_last_in;
  logic [DATA_WIDTH-1:0] w_shift_nxt;

  // Even parity is the XOR of the data; odd parity is its complement.
  function automatic logic f_parity(input logic [DATA_WIDTH-1:0] d,
                                    input logic odd);
    return odd ? ~^d : ^d;
  endfunction

  // Last cycle-counter value for the incoming prescale (0 behaves like 1).
  assign w_last_in   = (prescale == '0) ? '0 : prescale - 1'b1;
  assign w_bit_done  = (r_cnt == r_last);
  assign w_shift_nxt = r_shift >> 1;

  // The buffer is consumed when a frame starts: from IDLE, or straight
  // from the final stop cycle for back-to-back frames.
  assign w_load   = r_buf_full &&
                    ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_done));
  assign w_accept = DATA_VALID && !r_buf_full;

  assign ready  = ~r_buf_full;
  assign TX_OUT = r_tx;
  assign busy   = r_busy;

  // Holding buffer: filled by the handshake, emptied when a frame starts.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_buf_full <= 1'b0;
    end else if (w_load) begin
      r_buf_full <= 1'b0;
    end else if (w_accept) begin
      r_buf_full <= 1'b1;
      r_buf      <= P_DATA;
    end
  end

  // Frame FSM: sequences the bits and drives the registered serial line.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_last    <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
    end else if (w_load) begin
      r_state   <= S_START;
      r_shift   <= r_buf;
      r_par_en  <= PAR_EN;
      r_par_bit <= f_parity(r_buf, PAR_TYP);
      r_last    <= w_last_in;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_tx      <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          r_cnt  <= '0;
        end
        S_START: begin
          if (w_bit_done) begin
            r_cnt   <= '0;
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_done) begin
            r_cnt <= '0;
            if (r_bit == LAST_BIT) begin
              if (r_par_en) begin
                r_state <= S_PARITY;
                r_tx    <= r_par_bit;
              end else begin
                r_state <= S_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= w_shift_nxt;
              r_tx    <= w_shift_nxt[0];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_bit_done) begin
            r_cnt   <= '0;
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          // A full buffer at this point is handled by the w_load branch.
          if (w_bit_done) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_os.sv
// tb_uart_tx_os: directed scenarios plus randomized traffic, checked every
// cycle against a line-level model that expands each frame into the list of
// per-cycle line levels it should produce.
module tb_uart_tx_os;

  logic       CLK = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       dv;
  logic       ready;
  logic       par_en;
  logic       par_typ;
  logic [5:0] ps;
  logic       tx;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  // Model state: remaining line levels of the current frame, buffer contents.
  bit         mq[$];
  bit         m_full;
  logic [7:0] m_data;

  // Line samples taken while busy, for per-frame inspection.
  bit         tx_log[$];

  uart_tx_os #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK        (CLK),
    .RST        (rst),
    .P_DATA     (din),
    .DATA_VALID (dv),
    .ready      (ready),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .prescale   (ps),
    .TX_OUT     (tx),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expand one byte into its full frame of per-cycle line levels.
  task automatic build_frame(input logic [7:0] d);
    int p;
    p = (ps == 0) ? 1 : int'(ps);
    for (int k = 0; k < p; k++) mq.push_back(1'b0);
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < p; k++) mq.push_back(d[b]);
    if (par_en)
      for (int k = 0; k < p; k++) mq.push_back(par_typ ? ~^d : ^d);
    for (int k = 0; k < p; k++) mq.push_back(1'b1);
  endtask

  // Advance the model across one rising edge using the pre-edge inputs.
  task automatic model_edge();
    bit acc;
    if (rst) begin
      mq.delete();
      m_full = 1'b0;
    end else begin
      acc = dv && !m_full;
      if (mq.size() > 0) void'(mq.pop_front());
      if (mq.size() == 0 && m_full) begin
        build_frame(m_data);
        m_full = 1'b0;
      end
      if (acc) begin
        m_full = 1'b1;
        m_data = din;
      end
    end
  endtask

  // One clock: update the model, then compare outputs just after the edge.
  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    chk("tx",    tx,    (mq.size() > 0) ? mq[0] : 1'b1);
    chk("busy",  busy,  mq.size() > 0);
    chk("ready", ready, !m_full);
    if (busy === 1'b1) tx_log.push_back(tx);
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) chk("ready_timeout", 0, 1);
    din = d;
    dv  = 1'b1;
    step();
    dv  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((busy === 1'b1 || ready !== 1'b1) && n < 3000);
    if (n >= 3000) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    logic [9:0] pat;
    rst = 1'b1; din = '0; dv = 1'b0; par_en = 1'b0; par_typ = 1'b0; ps = 6'd8;
    mq.delete(); m_full = 1'b0; m_data = '0;

    // Reset, then a long idle stretch.
    step(); step();
    chk("rst_tx", tx, 1); chk("rst_busy", busy, 0); chk("rst_ready", ready, 1);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) step();
    chk("idle_tx", tx, 1);

    // prescale 8, no parity, 0xAB.
    tx_log.delete();
    send(8'hAB);
    wait_idle();
    chk("ab_len", tx_log.size(), 80);
    pat = 10'b1_1010_1011_0;
    if (tx_log.size() == 80)
      for (int i = 0; i < 10; i++) chk("ab_bit", tx_log[i*8+4], pat[i]);

    // prescale 16 with even then odd parity, 0xCD.
    ps = 6'd16; par_en = 1'b1; par_typ = 1'b0;
    tx_log.delete();
    send(8'hCD);
    wait_idle();
    chk("cd_even_len", tx_log.size(), 176);
    if (tx_log.size() == 176) chk("cd_even_par", tx_log[9*16+8], 1);
    par_typ = 1'b1;
    tx_log.delete();
    send(8'hCD);
    wait_idle();
    chk("cd_odd_len", tx_log.size(), 176);
    if (tx_log.size() == 176) chk("cd_odd_par", tx_log[9*16+8], 0);

    // prescale 32, odd parity, back-to-back frames 0xEF then 0x55.
    ps = 6'd32; par_en = 1'b1; par_typ = 1'b1;
    tx_log.delete();
    send(8'hEF);
    for (int i = 0; i < 5; i++) step();
    send(8'h55);
    chk("b2b_ready_drop", ready, 0);
    wait_idle();
    chk("b2b_len", tx_log.size(), 704);
    if (tx_log.size() == 704) begin
      chk("ef_par", tx_log[9*32+16], 0);
      chk("b2b_start2", tx_log[352], 0);
      chk("stop1_end", tx_log[351], 1);
      chk("55_par", tx_log[352+9*32+16], 1);
    end

    // Config change mid-frame: first frame keeps prescale 8 / no parity.
    ps = 6'd8; par_en = 1'b0; par_typ = 1'b0;
    tx_log.delete();
    send(8'hAB);
    send(8'h3C);
    for (int i = 0; i < 20; i++) step();
    ps = 6'd16; par_en = 1'b1;
    wait_idle();
    chk("cfg_len", tx_log.size(), 80 + 176);
    if (tx_log.size() == 256) begin
      chk("cfg_f1_stop", tx_log[9*8+4], 1);
      chk("cfg_f2_par", tx_log[80+9*16+8], 0);
    end

    // Reset during data bit 3, then a clean frame.
    ps = 6'd8; par_en = 1'b0;
    send(8'hAB);
    for (int i = 0; i < 8 + 3*8 + 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_tx", tx, 1); chk("mid_rst_busy", busy, 0); chk("mid_rst_ready", ready, 1);
    tx_log.delete();
    send(8'h3C);
    wait_idle();
    chk("post_rst_len", tx_log.size(), 80);
    pat = 10'b1_0011_1100_0;
    if (tx_log.size() == 80)
      for (int i = 0; i < 10; i++) chk("post_rst_bit", tx_log[i*8+4], pat[i]);

    // Randomized traffic with config changes and occasional resets.
    for (int i = 0; i < 6000; i++) begin
      dv  = ($urandom_range(0, 19) == 0);
      din = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        case ($urandom_range(0, 2))
          0:       ps = 6'd8;
          1:       ps = 6'd16;
          default: ps = 6'd32;
        endcase
        par_en  = 1'($urandom);
        par_typ = 1'($urandom);
      end
      rst = ($urandom_range(0, 2499) == 0);
      step();
    end
    dv = 1'b0; rst = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
